// File: rtl/dmem_wbuf.sv
// Posted-store write buffer between the CPU data port and dmem, with store-to-load forwarding.
// Optional store coalescing into buffered entries is enabled by defining WBUF_COALESCE_EN.
module dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] memAddr,
    input  logic [DW-1:0] memWriteData,
    input  logic          MemWrite,
    input  logic          MemRead,
    output logic [DW-1:0] memReadData,
    output logic          stall,
    output logic [AW-1:0] dmAddr,
    output logic [DW-1:0] dmWriteData,
    output logic          dmWrite,
    output logic          dmRead,
    input  logic [DW-1:0] dmReadData
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic          valid_r [DEPTH];
    logic [AW-3:0] waddr_r [DEPTH];
    logic [DW-1:0] wdata_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count;

    logic          full_s;
    logic          empty_s;
    logic          match_s;
    logic [PW-1:0] match_idx_s;
    logic          drain_s;
    logic          coalesce_s;
    logic          push_s;

    assign full_s  = (count == FULL_COUNT);
    assign empty_s = (count == {(PW+1){1'b0}});

    // Walk oldest to youngest so the last hit found is the youngest matching entry.
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        match_s     = 1'b0;
        match_idx_s = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx         = head_r + PW'(i);
            hit         = valid_r[idx] && (waddr_r[idx] == memAddr[AW-1:2]);
            match_idx_s = hit ? idx : match_idx_s;
            match_s     = match_s | hit;
        end
    end

    // Drain, accept and stall decisions, plus the dmem/CPU-facing datapath.
    always_comb begin
        drain_s = !reset && !empty_s && !MemRead && (!MemWrite || full_s);
`ifdef WBUF_COALESCE_EN
        // The head entry is leaving this cycle, so a store aimed at it must retry.
        coalesce_s = !reset && MemWrite && match_s && !(drain_s && (match_idx_s == head_r));
`else
        coalesce_s = 1'b0;
`endif
        push_s      = !reset && MemWrite && !coalesce_s && !full_s;
        stall       = !reset && MemWrite && !coalesce_s && full_s;
        dmWrite     = drain_s;
        dmRead      = !reset && MemRead;
        dmAddr      = MemRead ? memAddr : {waddr_r[head_r], 2'b00};
        dmWriteData = wdata_r[head_r];
        memReadData = reset ? {DW{1'b0}}
                    : ((MemRead && match_s) ? wdata_r[match_idx_s] : dmReadData);
    end

    // Pointer, occupancy and valid-bit state; reset discards any pending stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
            count  <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (drain_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            count <= count + (PW+1)'(push_s) - (PW+1)'(drain_s);
        end
    end

    // Entry payload; qualified by valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            waddr_r[tail_r] <= memAddr[AW-1:2];
            wdata_r[tail_r] <= memWriteData;
        end
        if (coalesce_s) begin
            wdata_r[match_idx_s] <= memWriteData;
        end
    end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Posted-store write buffer between the Beta's data-memory port and dmem.
- CPU stores are queued in a small FIFO and drained to dmem on cycles when the CPU is not reading.
- Loads go straight to dmem, or are forwarded from the youngest matching buffered store, so a load always sees program-order data.
- Provides a stall output for the processor when the buffer is full.

Parameters:
- DEPTH, 4: number of buffer entries; power of two, at least 2.
- DW, 32: data width.
- AW, 32: address width; byte address, word-aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; empties the buffer.
- memAddr  in  AW  CPU byte address.
- memWriteData  in  DW  CPU store data.
- MemWrite  in  1  CPU store request.
- MemRead  in  1  CPU load request; never asserted together with MemWrite.
- memReadData  out  DW  load data to CPU; combinational.
- stall  out  1  store not accepted this cycle; CPU must hold and retry.
- dmAddr  out  AW  address to dmem.
- dmWriteData  out  DW  write data to dmem.
- dmWrite  out  1  dmem write strobe; dmem writes on the rising edge.
- dmRead  out  1  dmem read enable.
- dmReadData  in  DW  dmem combinational read data.

Behaviour:
- Storage and state:
  - Circular FIFO of DEPTH entries {valid, wordAddr[AW-1:2], data}.
  - head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
- Reset, sampled at a rising edge:
  - head=tail=count=0 and all valid bits cleared.
  - Pending stores are discarded, including mid-drain.
  - While reset is high, dmWrite=0, dmRead=0, stall=0 and memReadData=0.
- Address match: compare memAddr[AW-1:2] only; low two bits ignored.
- Load cycle (MemRead=1):
  - dmRead=1, dmAddr=memAddr.
  - No drain occurs.
  - If any valid entry matches, memReadData = data of the youngest match (nearest to tail). Otherwise memReadData = dmReadData.
  - Zero-cycle latency, combinational.
- Store cycle (MemWrite=1):
  - Not full: push {memAddr[AW-1:2], memWriteData} at tail; tail++, count++ at the edge; stall=0.
  - Full: stall=1 combinationally and the store is dropped; the CPU re-presents it next cycle.
- Drain condition: non-empty AND MemRead=0 AND (MemWrite=0 OR full).
  - While draining: dmWrite=1, dmAddr={head wordAddr,2'b00}, dmWriteData=head data; head++, count-- at the edge.
  - A full-and-stalled cycle still drains, so the retried store succeeds the next cycle.
- Simultaneous push and drain is impossible by construction: a push needs not-full, a drain during a store needs full. count changes by at most ±1 per cycle.
- Idle cycle: dmRead=0. dmAddr and dmWriteData are don't-care when both strobes are low; drive the head entry.
- memReadData when MemRead=0 is don't-care; drive dmReadData.
- Ordering: dmem receives stores in program order, and each store is written exactly once.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Defined:
  - A store whose word address matches a valid entry overwrites the youngest matching entry's data in place; no push, count unchanged.
  - A coalesced store is accepted even when full, so stall = full AND no match.
  - Coalescing into the head entry on a drain cycle is forbidden: that store stalls instead.
- Undefined: every accepted store pushes a new entry, and duplicate addresses may coexist in the buffer.

Test Plan:
- Reset mid-drain: reset with 3 entries queued → count=0 next cycle, no further dmWrite, a subsequent load of 0x10 returns dmem's old value.
- Store then load: store 0x10←0xDEADBEEF, then immediate load 0x10 → memReadData=0xDEADBEEF while dmWrite=0; after an idle cycle dmem[0x10]=0xDEADBEEF.
- Youngest match wins: store 0x20←1, store 0x20←2, load 0x22 → memReadData=2 (low bits ignored); drain order dmem writes 1 then 2.
- Fill with no idle cycles (DEPTH=4): stores to 0x0,0x4,0x8,0xC, then store 0x30 → stall=1 and dmWrite=1 to 0x0 that cycle; retried 0x30 accepted with stall=0 next cycle.
- Read blocks drain: 2 entries queued plus 5 consecutive loads → dmWrite=0 throughout and count stays 2; drains resume on the first non-load cycle, 0x0 before 0x4.
- WBUF_COALESCE_EN: store 0x40←5, store 0x40←7 → count=1 and a single dmWrite of 7 to 0x40; without the macro, count=2 and two writes occur (5 then 7).
